// File: rtl/gt_rx_word_align.sv
// GT receive word aligner: finds the K28.5 comma lane and rotates data/K flags to byte 0.
// Optional WORD_ALIGN_REALIGN_CNT_EN adds realign_cnt and lock_lost outputs.
module gt_rx_word_align #(
  parameter logic [7:0]  COMMA        = 8'hBC,
  parameter int unsigned LOCK_CNT     = 4,
  parameter int unsigned MISMATCH_MAX = 3
) (
  input  logic        rst,
  input  logic        rx_clk,
  input  logic [31:0] gt_rx_data_in,
  input  logic [3:0]  gt_rx_ctrl_in,
  output logic [31:0] gt_rx_data,
  output logic [3:0]  gt_rx_ctrl,
  output logic        aligned,
`ifdef WORD_ALIGN_REALIGN_CNT_EN
  output logic [1:0]  byte_offset,
  output logic [15:0] realign_cnt,
  output logic        lock_lost
`else
  output logic [1:0]  byte_offset
`endif
);

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_CHECK    = 2'd1,
    S_LOCKED   = 2'd2
  } state_t;

  localparam logic [4:0] LC5 = 5'(LOCK_CNT);
  localparam logic [4:0] MM5 = 5'(MISMATCH_MAX);

  logic [31:0] r_p_data;
  logic [3:0]  r_p_ctrl;
  logic [31:0] r_out_data;
  logic [3:0]  r_out_ctrl;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_off;
  logic [1:0]  w_off_nxt;
  logic [3:0]  r_lock_cnt;
  logic [3:0]  w_lock_nxt;
  logic [3:0]  r_mis_cnt;
  logic [3:0]  w_mis_nxt;
  logic        r_aligned;
  logic        w_aligned_nxt;

  logic        w_hit;
  logic [1:0]  w_lane;
  logic [63:0] w_w;
  logic [7:0]  w_k;
  logic [31:0] w_rot_data;
  logic [3:0]  w_rot_ctrl;
  logic [4:0]  w_lock_sum;
  logic [4:0]  w_mis_sum;
  logic [3:0]  w_lock_inc;
  logic [3:0]  w_mis_inc;
  logic        w_drop;

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      r_p_data <= '0;
      r_p_ctrl <= '0;
    end else begin
      r_p_data <= gt_rx_data_in;
      r_p_ctrl <= gt_rx_ctrl_in;
    end
  end

  // Descending scan so the lowest matching lane wins.
  always_comb begin
    w_hit  = 1'b0;
    w_lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (r_p_ctrl[i] && (r_p_data[8*i +: 8] == COMMA)) begin
        w_hit  = 1'b1;
        w_lane = 2'(i);
      end
    end
  end

  assign w_w        = {gt_rx_data_in, r_p_data};
  assign w_k        = {gt_rx_ctrl_in, r_p_ctrl};
  assign w_rot_data = w_w[{r_off, 3'b000} +: 32];
  assign w_rot_ctrl = w_k[r_off +: 4];

  assign w_lock_sum = {1'b0, r_lock_cnt} + 5'd1;
  assign w_mis_sum  = {1'b0, r_mis_cnt} + 5'd1;
  assign w_lock_inc = (r_lock_cnt == 4'hF) ? 4'hF : w_lock_sum[3:0];
  assign w_mis_inc  = (r_mis_cnt == 4'hF) ? 4'hF : w_mis_sum[3:0];

  always_comb begin
    w_state_nxt   = r_state;
    w_off_nxt     = r_off;
    w_lock_nxt    = r_lock_cnt;
    w_mis_nxt     = r_mis_cnt;
    w_aligned_nxt = r_aligned;
    unique case (r_state)
      S_UNLOCKED: begin
        if (w_hit) begin
          w_off_nxt  = w_lane;
          w_lock_nxt = 4'd1;
          if (LC5 == 5'd1) begin
            w_state_nxt   = S_LOCKED;
            w_aligned_nxt = 1'b1;
          end else begin
            w_state_nxt = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (w_hit && (w_lane == r_off)) begin
          w_lock_nxt = w_lock_inc;
          if (w_lock_sum == LC5) begin
            w_state_nxt   = S_LOCKED;
            w_aligned_nxt = 1'b1;
          end
        end else if (w_hit) begin
          w_off_nxt  = w_lane;
          w_lock_nxt = 4'd1;
        end
      end
      S_LOCKED: begin
        if (w_hit && (w_lane == r_off)) begin
          w_mis_nxt = 4'd0;
        end else if (w_hit) begin
          w_mis_nxt = w_mis_inc;
          if (w_mis_sum == MM5) begin
            w_state_nxt   = S_UNLOCKED;
            w_aligned_nxt = 1'b0;
            w_mis_nxt     = 4'd0;
          end
        end
      end
      default: begin
        w_state_nxt   = S_UNLOCKED;
        w_aligned_nxt = 1'b0;
      end
    endcase
  end

  assign w_drop = (r_state == S_LOCKED) && (w_state_nxt == S_UNLOCKED);

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_UNLOCKED;
      r_off      <= 2'd0;
      r_lock_cnt <= 4'd0;
      r_mis_cnt  <= 4'd0;
      r_aligned  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_off      <= w_off_nxt;
      r_lock_cnt <= w_lock_nxt;
      r_mis_cnt  <= w_mis_nxt;
      r_aligned  <= w_aligned_nxt;
    end
  end

  // Pre-edge offset and aligned: the lock-completing comma leaves with ctrl=0.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      r_out_data <= '0;
      r_out_ctrl <= '0;
    end else begin
      r_out_data <= w_rot_data;
      r_out_ctrl <= w_rot_ctrl & {4{r_aligned}};
    end
  end

  assign gt_rx_data  = r_out_data;
  assign gt_rx_ctrl  = r_out_ctrl;
  assign aligned     = r_aligned;
  assign byte_offset = r_off;

`ifdef WORD_ALIGN_REALIGN_CNT_EN
  logic [15:0] r_realign_cnt;
  logic        r_lock_lost;

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      r_realign_cnt <= 16'd0;
      r_lock_lost   <= 1'b0;
    end else begin
      r_lock_lost <= w_drop;
      if (w_drop && (r_realign_cnt != 16'hFFFF))
        r_realign_cnt <= r_realign_cnt + 16'd1;
    end
  end

  assign realign_cnt = r_realign_cnt;
  assign lock_lost   = r_lock_lost;
`else
  logic w_unused;
  assign w_unused = w_drop;
`endif

endmodule

// File: tb/tb_gt_rx_word_align.sv
// Directed bench for gt_rx_word_align with default parameters.
// Covers lane 0/1/2/3 lock, restart in CHECK, lock loss and async reset.
module tb_gt_rx_word_align;

  logic        rst;
  logic        rx_clk;
  logic [31:0] gt_rx_data_in;
  logic [3:0]  gt_rx_ctrl_in;
  logic [31:0] gt_rx_data;
  logic [3:0]  gt_rx_ctrl;
  logic        aligned;
  logic [1:0]  byte_offset;
`ifdef WORD_ALIGN_REALIGN_CNT_EN
  logic [15:0] realign_cnt;
  logic        lock_lost;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] C0  = 32'h1234_56BC;
  localparam logic [31:0] FB  = 32'hBCBC_BCBC;
  localparam logic [31:0] W1  = 32'h0000_BC00;
  localparam logic [31:0] W1B = 32'hBC00_BC00;
  localparam logic [31:0] W2  = 32'h11BC_2233;
  localparam logic [31:0] N2  = 32'h4455_6677;
  localparam logic [31:0] W3  = 32'hBC00_0000;
  localparam logic [31:0] N3  = 32'hAABB_CCDD;
  localparam logic [31:0] K3C = 32'h0000_003C;

  gt_rx_word_align dut (
    .rst           (rst),
    .rx_clk        (rx_clk),
    .gt_rx_data_in (gt_rx_data_in),
    .gt_rx_ctrl_in (gt_rx_ctrl_in),
    .gt_rx_data    (gt_rx_data),
    .gt_rx_ctrl    (gt_rx_ctrl),
    .aligned       (aligned),
`ifdef WORD_ALIGN_REALIGN_CNT_EN
    .byte_offset   (byte_offset),
    .realign_cnt   (realign_cnt),
    .lock_lost     (lock_lost)
`else
    .byte_offset   (byte_offset)
`endif
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [31:0] d, input logic [3:0] k);
    gt_rx_data_in = d;
    gt_rx_ctrl_in = k;
    @(posedge rx_clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    gt_rx_data_in = '0;
    gt_rx_ctrl_in = '0;
    #12;
    chk("rst_data", gt_rx_data, 32'h0);
    chk("rst_ctrl", {28'h0, gt_rx_ctrl}, 32'h0);
    chk("rst_aligned", {31'h0, aligned}, 32'h0);
    chk("rst_off", {30'h0, byte_offset}, 32'h0);
    @(negedge rx_clk);
    rst = 1'b0;

    // lane 0, comma every 8 words; BC without K must not count
    for (int i = 0; i < 3; i++) begin
      cyc(C0, 4'b0001);
      repeat (7) cyc(FB, 4'b0000);
    end
    chk("l0_pre_aligned", {31'h0, aligned}, 32'h0);
    cyc(C0, 4'b0001);
    chk("l0_c4_in_p", {31'h0, aligned}, 32'h0);
    cyc(FB, 4'b0000);
    chk("l0_aligned", {31'h0, aligned}, 32'h1);
    chk("l0_off", {30'h0, byte_offset}, 32'h0);
    chk("l0_c4_data", gt_rx_data, C0);
    chk("l0_c4_ctrl", {28'h0, gt_rx_ctrl}, 32'h0);
    repeat (6) cyc(FB, 4'b0000);
    cyc(C0, 4'b0001);
    cyc(FB, 4'b0000);
    chk("l0_c5_data", gt_rx_data, C0);
    chk("l0_c5_ctrl", {28'h0, gt_rx_ctrl}, 32'h1);
    cyc(FB, 4'b0000);
    chk("l0_fb_ctrl", {28'h0, gt_rx_ctrl}, 32'h0);

    // two wrong lanes then a correct one: lock holds
    cyc(W2, 4'b0100); cyc(N2, 4'b0000);
    cyc(W2, 4'b0100); cyc(N2, 4'b0000);
    cyc(C0, 4'b0001); cyc(N2, 4'b0000);
    chk("mis_hold_aligned", {31'h0, aligned}, 32'h1);
    chk("mis_hold_off", {30'h0, byte_offset}, 32'h0);
    chk("mis_hold_ctrl", {28'h0, gt_rx_ctrl}, 32'h1);

    // three wrong lanes: lock drops
    cyc(W2, 4'b0100); cyc(N2, 4'b0000);
    cyc(W2, 4'b0100); cyc(N2, 4'b0000);
    chk("mis2_aligned", {31'h0, aligned}, 32'h1);
    cyc(W2, 4'b0100); cyc(K3C, 4'b0001);
    chk("drop_aligned", {31'h0, aligned}, 32'h0);
    chk("drop_off", {30'h0, byte_offset}, 32'h0);
    chk("drop_last_data", gt_rx_data, W2);
    chk("drop_last_ctrl", {28'h0, gt_rx_ctrl}, 32'h4);
`ifdef WORD_ALIGN_REALIGN_CNT_EN
    chk("drop_lost", {31'h0, lock_lost}, 32'h1);
    chk("drop_cnt", {16'h0, realign_cnt}, 32'h1);
`endif
    cyc(N2, 4'b0000);
    chk("gated_data", gt_rx_data, K3C);
    chk("gated_ctrl", {28'h0, gt_rx_ctrl}, 32'h0);
`ifdef WORD_ALIGN_REALIGN_CNT_EN
    chk("lost_pulse_end", {31'h0, lock_lost}, 32'h0);
    chk("cnt_hold", {16'h0, realign_cnt}, 32'h1);
`endif

    // relock on lane 2
    repeat (4) begin
      cyc(W2, 4'b0100); cyc(N2, 4'b0000);
    end
    chk("l2_aligned", {31'h0, aligned}, 32'h1);
    chk("l2_off", {30'h0, byte_offset}, 32'h2);
    chk("l2_c4_data", gt_rx_data, 32'h6677_11BC);
    chk("l2_c4_ctrl", {28'h0, gt_rx_ctrl}, 32'h0);
    cyc(W2, 4'b0100); cyc(N2, 4'b0000);
    chk("l2_c5_data", gt_rx_data, 32'h6677_11BC);
    chk("l2_c5_ctrl", {28'h0, gt_rx_ctrl}, 32'h1);

    // asynchronous reset mid-packet
    cyc(W2, 4'b0100);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_data", gt_rx_data, 32'h0);
    chk("arst_ctrl", {28'h0, gt_rx_ctrl}, 32'h0);
    chk("arst_aligned", {31'h0, aligned}, 32'h0);
    chk("arst_off", {30'h0, byte_offset}, 32'h0);
`ifdef WORD_ALIGN_REALIGN_CNT_EN
    chk("arst_cnt", {16'h0, realign_cnt}, 32'h0);
`endif
    @(negedge rx_clk);
    rst = 1'b0;

    // lane 3: rest of the word comes from the next input
    repeat (3) begin
      cyc(W3, 4'b1000); cyc(N3, 4'b0000);
    end
    chk("l3_not_yet", {31'h0, aligned}, 32'h0);
    chk("l3_off", {30'h0, byte_offset}, 32'h3);
    cyc(W3, 4'b1000); cyc(N3, 4'b0000);
    chk("l3_aligned", {31'h0, aligned}, 32'h1);
    cyc(W3, 4'b1000); cyc(N3, 4'b0000);
    chk("l3_data", gt_rx_data, 32'hBBCC_DDBC);
    chk("l3_ctrl", {28'h0, gt_rx_ctrl}, 32'h1);

    // lane change during CHECK restarts the count
    rst = 1'b1;
    #3;
    @(negedge rx_clk);
    rst = 1'b0;
    cyc(C0, 4'b0001); cyc(FB, 4'b0000);
    cyc(C0, 4'b0001); cyc(FB, 4'b0000);
    chk("chk_l0_off", {30'h0, byte_offset}, 32'h0);
    cyc(W1, 4'b0010); cyc(FB, 4'b0000);
    chk("chk_l1_off", {30'h0, byte_offset}, 32'h1);
    chk("chk_l1_aligned", {31'h0, aligned}, 32'h0);
    cyc(W1B, 4'b1010); cyc(FB, 4'b0000);
    cyc(W1, 4'b0010); cyc(FB, 4'b0000);
    chk("chk_l1_3", {31'h0, aligned}, 32'h0);
    chk("chk_l1_lowest", {30'h0, byte_offset}, 32'h1);
    cyc(W1, 4'b0010); cyc(FB, 4'b0000);
    chk("chk_l1_locked", {31'h0, aligned}, 32'h1);
    cyc(W1B, 4'b1010); cyc(FB, 4'b0000);
    chk("l1_multi_data", gt_rx_data, 32'hBCBC_00BC);
    chk("l1_multi_ctrl", {28'h0, gt_rx_ctrl}, 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
